axi_rd_arbiter: RTL and testbench

//  Shares the single AXI3 read channel between icache refill, dcache refill and uncached loads.
//  One outstanding read transaction at a time. Data-side requests win by fixed priority,
//  so a mem_stall clears before an icache_stall; a starvation counter bounds icache wait.

---
 rtl/axi_rd_arbiter_pkg.sv | 39 +++
 rtl/axi_rd_prio_sel.sv | 38 +++
 rtl/axi_rd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Purpose: shared types, widths and encodings for the AXI3 read-channel arbiter.
// Contents: requester indices, AXI field widths, burst encoding, FSM state
//           encoding, latched-command payload struct, owner-to-ID helper.
package axi_rd_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned OWNER_W = 2;

  localparam int unsigned REQ_ICACHE   = 0;
  localparam int unsigned REQ_DCACHE   = 1;
  localparam int unsigned REQ_UNCACHED = 2;

  localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;

  // Request payload latched into the AR registers at arbitration time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } rd_cmd_t;

  // AXI ID is the requester index zero-extended.
  function automatic logic [ID_W-1:0] owner_to_id(input logic [OWNER_W-1:0] owner);
    return ID_W'(owner);
  endfunction

endpackage

// File: rtl/axi_rd_prio_sel.sv
// Purpose: combinational winner pick among read requesters.
// Ports: req_i     - per-requester request
//        starve_i  - icache starvation threshold reached
//        win_oh_o  - one-hot winner (all zero when no request)
//        win_idx_o - winner index
//        any_o     - at least one request pending
module axi_rd_prio_sel
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic               starve_i,
  output logic [NREQ-1:0]    win_oh_o,
  output logic [OWNER_W-1:0] win_idx_o,
  output logic               any_o
);

  // Ascending scan leaves the highest requesting index as winner; a starved
  // icache overrides the fixed priority.
  always_comb begin
    win_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i]) win_idx_o = OWNER_W'(i);
    end
    if (starve_i && req_i[REQ_ICACHE]) win_idx_o = OWNER_W'(REQ_ICACHE);
  end

  // One-hot form of the winner, qualified by any request present.
  always_comb begin
    any_o    = |req_i;
    win_oh_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh_o[i] = any_o && (win_idx_o == OWNER_W'(i));
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Purpose: shares one AXI3 read channel between icache refill, dcache refill and
//          uncached loads, one outstanding transaction at a time.
// Ports: clk/resetn                    - clock, synchronous active-low reset
//        rd_req/rd_addr/rd_len/rd_size - packed per-requester read commands
//        rd_gnt                        - AR-handshake pulse to the owner (combinational)
//        ret_valid/ret_last/ret_err/ret_data - R beat routed to the owner (combinational)
//        busy                          - FSM not idle
//        ar*                           - AXI3 AR master channel (registered)
//        r*                            - AXI3 R channel, rready combinational on state
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        rd_req,
  input  logic [NREQ*ADDR_W-1:0] rd_addr,
  input  logic [NREQ*LEN_W-1:0]  rd_len,
  input  logic [NREQ*SIZE_W-1:0] rd_size,
  output logic [NREQ-1:0]        rd_gnt,
  output logic [NREQ-1:0]        ret_valid,
  output logic                   ret_last,
  output logic                   ret_err,
  output logic [DATA_W-1:0]      ret_data,
  output logic                   busy,
  output logic [ID_W-1:0]        arid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [LEN_W-1:0]       arlen,
  output logic [SIZE_W-1:0]      arsize,
  output logic [BURST_W-1:0]     arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [ID_W-1:0]        rid,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [RESP_W-1:0]      rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  rd_cmd_t            cmd_q, cmd_d;
  logic               arvalid_q, arvalid_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic [NREQ-1:0]    win_oh;
  logic [OWNER_W-1:0] win_idx;
  logic               win_any;
  logic               starve_hit;
  rd_cmd_t            win_cmd;
  logic [NREQ-1:0]    owner_oh;
  logic               unused_rresp0;

  assign unused_rresp0 = rresp[0];
  assign starve_hit    = (starve_cnt_q == CNT_W'(STARVE_MAX));

  axi_rd_prio_sel #(
    .NREQ (NREQ)
  ) u_prio_sel (
    .req_i     (rd_req),
    .starve_i  (starve_hit),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  // Select the winner's command slice.
  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_cmd.addr = rd_addr[i*ADDR_W +: ADDR_W];
        win_cmd.len  = rd_len[i*LEN_W +: LEN_W];
        win_cmd.size = rd_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; arvalid is always high in AR so arready alone completes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (win_any)          state_d = ARB_AR;
      ARB_AR:   if (arready)          state_d = ARB_R;
      ARB_R:    if (rvalid && rlast)  state_d = ARB_IDLE;
      default:                        state_d = ARB_IDLE;
    endcase
  end

  // Output logic: grant and return routing follow the latched owner.
  always_comb begin
    owner_oh  = NREQ'(1) << owner_q;
    rd_gnt    = '0;
    ret_valid = '0;
    ret_last  = 1'b0;
    ret_err   = 1'b0;
    ret_data  = '0;
    rready    = 1'b0;
    busy      = (state_q != ARB_IDLE);
    unique case (state_q)
      ARB_AR: if (arready) rd_gnt = owner_oh;
      ARB_R: begin
        rready = 1'b1;
        if (rvalid) begin
          ret_valid = owner_oh;
          ret_data  = rdata;
          ret_last  = rlast;
          ret_err   = rresp[1];
        end
      end
      default: ;
    endcase
  end

  // AR registers, owner and starvation counter.
  always_comb begin
    cmd_d        = cmd_q;
    arvalid_d    = arvalid_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!rd_req[REQ_ICACHE] || (win_idx == OWNER_W'(REQ_ICACHE))) begin
          starve_cnt_d = '0;
        end else if (!starve_hit) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        if (win_any) begin
          cmd_d     = win_cmd;
          owner_d   = win_idx;
          arvalid_d = 1'b1;
        end
      end
      ARB_AR: if (arready) arvalid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_q        <= '0;
      arvalid_q    <= 1'b0;
      owner_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      cmd_q        <= cmd_d;
      arvalid_q    <= arvalid_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign arid    = owner_to_id(owner_q);
  assign araddr  = cmd_q.addr;
  assign arlen   = cmd_q.len;
  assign arsize  = cmd_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;

  // Single outstanding read: any returning ID other than ours is a slave bug.
  always_ff @(posedge clk) begin
    if (resetn && (state_q == ARB_R) && rvalid) begin
      assert (rid == arid);
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic        clk;
  logic        resetn;
  logic [2:0]  rd_req;
  logic [95:0] rd_addr;
  logic [11:0] rd_len;
  logic [8:0]  rd_size;
  logic [2:0]  rd_gnt;
  logic [2:0]  ret_valid;
  logic        ret_last;
  logic        ret_err;
  logic [31:0] ret_data;
  logic        busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [2:0] G_IC = 3'(1 << REQ_ICACHE);
  localparam logic [2:0] G_DC = 3'(1 << REQ_DCACHE);
  localparam logic [2:0] G_UC = 3'(1 << REQ_UNCACHED);

  axi_rd_arbiter #(.NREQ(3), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .rd_size   (rd_size),
    .rd_gnt    (rd_gnt),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_err   (ret_err),
    .ret_data  (ret_data),
    .busy      (busy),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle with rd_req already driven; ends in the IDLE cycle
  // following the last beat.
  task automatic do_xact(input string tag, input logic [2:0] exp_gnt,
                         input logic [31:0] exp_addr, input logic [3:0] exp_len,
                         input logic [2:0] exp_size, input logic [3:0] exp_id,
                         input logic [2:0] keep, input int gap, input logic [1:0] resp);
    logic [31:0] d;
    arready = 1'b1;
    #1;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle arvalid"}, 32'(arvalid), 32'd0);
    step();
    chk({tag, " arvalid"}, 32'(arvalid), 32'd1);
    chk({tag, " arid"}, 32'(arid), 32'(exp_id));
    chk({tag, " araddr"}, araddr, exp_addr);
    chk({tag, " arlen"}, 32'(arlen), 32'(exp_len));
    chk({tag, " arsize"}, 32'(arsize), 32'(exp_size));
    chk({tag, " gnt"}, 32'(rd_gnt), 32'(exp_gnt));
    rd_req = rd_req & ~(exp_gnt & ~keep);
    step();
    chk({tag, " rready"}, 32'(rready), 32'd1);
    chk({tag, " gnt pulse end"}, 32'(rd_gnt), 32'd0);
    chk({tag, " arvalid drop"}, 32'(arvalid), 32'd0);
    for (int b = 0; b <= int'(exp_len); b++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        #1;
        chk({tag, " gap ret_valid"}, 32'(ret_valid), 32'd0);
        step();
      end
      d      = exp_addr + 32'(b * 4);
      rvalid = 1'b1;
      rid    = exp_id;
      rdata  = d;
      rlast  = (b == int'(exp_len));
      rresp  = resp;
      #1;
      chk({tag, " ret_valid"}, 32'(ret_valid), 32'(exp_gnt));
      chk({tag, " ret_data"}, ret_data, d);
      chk({tag, " ret_last"}, 32'(ret_last), 32'(b == int'(exp_len)));
      chk({tag, " ret_err"}, 32'(ret_err), 32'(resp[1]));
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    resetn  = 1'b0;
    rd_req  = '0;
    rd_addr = '0;
    rd_len  = '0;
    rd_size = '0;
    arready = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    step();
    step();
    #1;
    chk("rst arvalid", 32'(arvalid), 32'd0);
    chk("rst rready", 32'(rready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst gnt", 32'(rd_gnt), 32'd0);
    chk("rst ret_valid", 32'(ret_valid), 32'd0);
    chk("rst arid", 32'(arid), 32'd0);
    chk("rst araddr", araddr, 32'd0);
    chk("rst arlen", 32'(arlen), 32'd0);
    chk("rst arburst", 32'(arburst), 32'd1);
    resetn = 1'b1;
    step();

    // 1: single icache refill, 8 beats.
    rd_addr[31:0] = 32'h1fc0_0000; rd_len[3:0] = 4'd7; rd_size[2:0] = 3'd2;
    rd_req = G_IC;
    do_xact("t1", G_IC, 32'h1fc0_0000, 4'd7, 3'd2, 4'd0, 3'b000, 0, 2'b00);
    #1;
    chk("t1 busy after last", 32'(busy), 32'd0);

    // 2: dcache beats icache, icache follows after one idle cycle.
    rd_addr[31:0]  = 32'h1fc0_0040; rd_len[3:0] = 4'd3;
    rd_addr[63:32] = 32'h8000_0100; rd_len[7:4] = 4'd3; rd_size[5:3] = 3'd3;
    rd_req = G_DC | G_IC;
    do_xact("t2d", G_DC, 32'h8000_0100, 4'd3, 3'd3, 4'd1, 3'b000, 0, 2'b00);
    do_xact("t2i", G_IC, 32'h1fc0_0040, 4'd3, 3'd2, 4'd0, 3'b000, 0, 2'b00);

    // 3: dcache re-requests continuously; 5th pick goes to the starved icache.
    rd_addr[31:0]  = 32'h1fc0_0200; rd_len[3:0] = 4'd0;
    rd_addr[63:32] = 32'h8000_0300; rd_len[7:4] = 4'd1;
    rd_req = G_DC | G_IC;
    do_xact("t3d1", G_DC, 32'h8000_0300, 4'd1, 3'd3, 4'd1, G_DC, 0, 2'b00);
    do_xact("t3d2", G_DC, 32'h8000_0300, 4'd1, 3'd3, 4'd1, G_DC, 0, 2'b00);
    do_xact("t3d3", G_DC, 32'h8000_0300, 4'd1, 3'd3, 4'd1, G_DC, 0, 2'b00);
    do_xact("t3d4", G_DC, 32'h8000_0300, 4'd1, 3'd3, 4'd1, G_DC, 0, 2'b00);
    #1;
    chk("t3 starve at max", 32'(dut.starve_cnt_q), 32'd4);
    do_xact("t3i5", G_IC, 32'h1fc0_0200, 4'd0, 3'd2, 4'd0, G_DC, 0, 2'b00);
    #1;
    chk("t3 starve cleared", 32'(dut.starve_cnt_q), 32'd0);
    rd_req = G_DC | G_IC;
    do_xact("t3d6", G_DC, 32'h8000_0300, 4'd1, 3'd3, 4'd1, 3'b000, 0, 2'b00);
    do_xact("t3i7", G_IC, 32'h1fc0_0200, 4'd0, 3'd2, 4'd0, 3'b000, 0, 2'b00);

    // 4: arready withheld for 10 cycles.
    arready = 1'b0;
    rd_addr[63:32] = 32'h8000_0200; rd_len[7:4] = 4'd0;
    rd_req = G_DC;
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4 hold arvalid", 32'(arvalid), 32'd1);
      chk("t4 hold araddr", araddr, 32'h8000_0200);
      chk("t4 hold no gnt", 32'(rd_gnt), 32'd0);
      step();
    end
    arready = 1'b1;
    #1;
    chk("t4 gnt", 32'(rd_gnt), 32'(G_DC));
    rd_req = '0;
    step();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h0bad_f00d; rlast = 1'b1;
    #1;
    chk("t4 ret_valid", 32'(ret_valid), 32'(G_DC));
    chk("t4 ret_last", 32'(ret_last), 32'd1);
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // 5: reset during beat 3 of 8.
    rd_addr[31:0] = 32'h1fc0_0100; rd_len[3:0] = 4'd7;
    rd_req = G_IC;
    step();
    #1;
    chk("t5 gnt", 32'(rd_gnt), 32'(G_IC));
    rd_req = '0;
    step();
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rid = 4'd0; rdata = 32'(b); rlast = 1'b0;
      #1;
      chk("t5 beat ret_valid", 32'(ret_valid), 32'(G_IC));
      step();
    end
    resetn = 1'b0;
    rdata  = 32'd2;
    step();
    #1;
    chk("t5 rready", 32'(rready), 32'd0);
    chk("t5 ret_valid", 32'(ret_valid), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 gnt", 32'(rd_gnt), 32'd0);
    chk("t5 arvalid", 32'(arvalid), 32'd0);
    resetn = 1'b1;
    rvalid = 1'b0;
    step();

    // 6: uncached single beat with gaps and SLVERR beats dcache; dcache follows.
    rd_addr[95:64] = 32'hbfc0_1234; rd_len[11:8] = 4'd0; rd_size[8:6] = 3'd0;
    rd_addr[63:32] = 32'h8000_0400; rd_len[7:4]  = 4'd0;
    rd_req = G_UC | G_DC;
    do_xact("t6u", G_UC, 32'hbfc0_1234, 4'd0, 3'd0, 4'd2, 3'b000, 2, 2'b10);
    do_xact("t6d", G_DC, 32'h8000_0400, 4'd0, 3'd3, 4'd1, 3'b000, 0, 2'b00);
    #1;
    chk("t6 final busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
